// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and instruction memory.
//   imem_req   : fetch request, driven by the fetch unit
//   imem_addr  : fetch address, driven by the fetch unit
//   imem_ack   : memory has valid imem_rdata this cycle
//   imem_rdata : 16-bit instruction word from memory
//
// Handshake: a transfer completes on the rising edge where imem_req=1 and
// imem_ack=1. While imem_req=1 the address is held constant. Memory may
// raise imem_ack in the same cycle imem_req first reads 1. imem_ack with
// imem_req=0 carries no meaning and is ignored by the fetch unit.
interface instr_fetch_unit_if #(
  parameter int PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  // Fetch unit side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Instruction memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the multicycle core.
// Owns the PC and the instruction register (IR). It fetches one 16-bit
// instruction per PC value over the imem req/ack handshake, slices the IR
// into decode fields, and applies the control unit's PCen/PCsrc to step
// the PC and launch the next fetch.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   PCen            1-cycle pulse: advance PC and launch next fetch
//   PCsrc           next-PC select (00 pc+1, 01 branch, 10 jump, 11 ret)
//   ret_addr        return address used by PCsrc=11
//   imem            instruction-memory bus (master side)
//   pc, pc_plus1    current PC and pc+1 (link value for CALL)
//   ir_valid        IR holds the instruction at pc
//   opcode..jofs    raw IR slices, meaningful only while ir_valid=1
//   pcen_err        sticky: PCen seen outside READY
//   state_dbg       current FSM state, for observation only
module instr_fetch_unit #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PCen,
  input  logic [1:0]          PCsrc,
  input  logic [PC_W-1:0]     ret_addr,
  instr_fetch_unit_if.master  imem,
  output logic [PC_W-1:0]     pc,
  output logic [PC_W-1:0]     pc_plus1,
  output logic                ir_valid,
  output logic [3:0]          opcode,
  output logic                m,
  output logic [2:0]          rd,
  output logic [2:0]          rs1,
  output logic [2:0]          rs2,
  output logic [2:0]          i_rd,
  output logic [2:0]          i_rs1,
  output logic [4:0]          imm5,
  output logic [11:0]         jofs,
  output logic                pcen_err,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]      state;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir;
  logic            ir_valid_q;
  logic            req_q;
  logic            err_q;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] jmp_target;
  logic [PC_W-1:0] br_target;

  // Jump keeps the PC bits above the 12-bit offset field.
  if (PC_W > 12) begin : g_wide_pc
    assign jmp_target = {pc_q[PC_W-1:12], ir[11:0]};
  end else begin : g_narrow_pc
    assign jmp_target = ir[11:0];
  end

  assign br_target = pc_q + {{(PC_W-5){ir[4]}}, ir[4:0]};
  assign pc_plus1  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  always_comb begin
    next_pc = pc_plus1;
    case (PCsrc)
      2'b00:   next_pc = pc_plus1;
      2'b01:   next_pc = br_target;
      2'b10:   next_pc = jmp_target;
      default: next_pc = ret_addr;
    endcase
  end

  // req_q is 1 for exactly the FETCH state, so ack outside a fetch is
  // never looked at, and ir_valid (set only on leaving FETCH) can never
  // overlap a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BOOT;
      pc_q       <= RESET_PC;
      ir         <= 16'h0000;
      ir_valid_q <= 1'b0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (PCen && (state != ST_READY)) begin
        err_q <= 1'b1;
      end
      case (state)
        ST_BOOT: begin
          req_q <= 1'b1;
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem.imem_ack) begin
            ir         <= imem.imem_rdata;
            ir_valid_q <= 1'b1;
            req_q      <= 1'b0;
            state      <= ST_READY;
          end
        end
        ST_READY: begin
          if (PCen) begin
            pc_q       <= next_pc;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_BOOT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;

  assign pc        = pc_q;
  assign ir_valid  = ir_valid_q;
  assign pcen_err  = err_q;
  assign state_dbg = state;

  assign opcode = ir[15:12];
  assign m      = ir[11];
  assign rd     = ir[11:9];
  assign rs1    = ir[8:6];
  assign rs2    = ir[5:3];
  assign i_rd   = ir[10:8];
  assign i_rs1  = ir[7:5];
  assign imm5   = ir[4:0];
  assign jofs   = ir[11:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        PCen;
  logic [1:0]  PCsrc;
  logic [15:0] ret_addr;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        ir_valid;
  logic [3:0]  opcode;
  logic        m;
  logic [2:0]  rd, rs1, rs2, i_rd, i_rs1;
  logic [4:0]  imm5;
  logic [11:0] jofs;
  logic        pcen_err;
  logic [1:0]  state_dbg;

  instr_fetch_unit_if #(.PC_W(16)) bus ();

  instr_fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .PCen      (PCen),
    .PCsrc     (PCsrc),
    .ret_addr  (ret_addr),
    .imem      (bus),
    .pc        (pc),
    .pc_plus1  (pc_plus1),
    .ir_valid  (ir_valid),
    .opcode    (opcode),
    .m         (m),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .i_rd      (i_rd),
    .i_rs1     (i_rs1),
    .imm5      (imm5),
    .jofs      (jofs),
    .pcen_err  (pcen_err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [15:0] ovr_addr;
  logic [15:0] ovr_data;
  int          wait_target;
  int          wait_cnt;
  logic        ack_force;

  function automatic logic [15:0] instr_at(input logic [15:0] a);
    logic [31:0] h;
    if (a == ovr_addr) return ovr_data;
    h = {16'h0000, a} * 32'h0000_6F1B;
    return h[15:0] ^ 16'hA5C3;
  endfunction

  // Memory acks after wait_target wait cycles; ack_force injects a stray ack.
  assign bus.imem_ack   = (bus.imem_req && (wait_cnt == wait_target)) || ack_force;
  assign bus.imem_rdata = ack_force ? 16'hBEEF :
                          (bus.imem_ack ? instr_at(bus.imem_addr) : 16'hDEAD);

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // ---------------- scoreboard ----------------
  int n_pass;
  int n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference next-PC, plain arithmetic on the instruction word.
  function automatic logic [15:0] model_next(input logic [15:0] p, input logic [15:0] ins,
                                             input logic [1:0] s, input logic [15:0] r);
    int off;
    int sum;
    case (s)
      2'd0: begin sum = int'(p) + 1; return sum[15:0]; end
      2'd1: begin
        off = int'(ins[4:0]);
        if (off >= 16) off = off - 32;
        sum = int'(p) + off;
        return sum[15:0];
      end
      2'd2: return (p & 16'hF000) | {4'h0, ins[11:0]};
      default: return r;
    endcase
  endfunction

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!ir_valid && k < 64) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, ir_valid}, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after the PCen edge.
  task automatic pulse_pcen(input logic [1:0] s, input logic [15:0] r);
    PCen     = 1'b1;
    PCsrc    = s;
    ret_addr = r;
    @(negedge clk);
    PCen = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] start_pc;
    logic [15:0] instr;
    logic [1:0]  src;
    logic [15:0] ret;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[8];
  logic [15:0] model_pc;
  logic [15:0] p_hold;
  logic [15:0] ins;

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; PCen = 1'b0; PCsrc = 2'b00; ret_addr = 16'h0000;
    wait_target = 0; ack_force = 1'b0;
    ovr_addr = 16'hFFF7; ovr_data = 16'h0000;

    vecs[0] = '{16'h0005, 16'h1000, 2'b00, 16'h0000, 16'h0006};
    vecs[1] = '{16'h000A, 16'h201E, 2'b01, 16'h0000, 16'h0008};
    vecs[2] = '{16'hFFFF, 16'h0000, 2'b00, 16'h0000, 16'h0000};
    vecs[3] = '{16'h3005, 16'hC0A0, 2'b10, 16'h0000, 16'h30A0};
    vecs[4] = '{16'h4321, 16'h0000, 2'b11, 16'h1234, 16'h1234};
    vecs[5] = '{16'h0002, 16'h300F, 2'b01, 16'h0000, 16'h0011};
    vecs[6] = '{16'h0000, 16'h4010, 2'b01, 16'h0000, 16'hFFF0};
    vecs[7] = '{16'hABCD, 16'hDFFF, 2'b10, 16'h0000, 16'hAFFF};

    // ---- reset state and zero-wait boot ----
    repeat (2) @(negedge clk);
    check("rst_pc", {16'd0, pc}, 32'h0);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_irv", {31'd0, ir_valid}, 32'd0);
    check("rst_err", {31'd0, pcen_err}, 32'd0);
    check("rst_ir", {16'd0, opcode, jofs}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("boot_req", {31'd0, bus.imem_req}, 32'd1);
    check("boot_addr", {16'd0, bus.imem_addr}, 32'h0);
    check("boot_irv0", {31'd0, ir_valid}, 32'd0);
    @(negedge clk);
    check("boot_irv1", {31'd0, ir_valid}, 32'd1);
    check("boot_req0", {31'd0, bus.imem_req}, 32'd0);
    check("boot_ir", {16'd0, opcode, jofs}, {16'd0, instr_at(16'h0000)});
    model_pc = 16'h0000;

    // ---- table of next-PC cases ----
    for (int i = 0; i < 8; i++) begin
      ovr_addr = vecs[i].start_pc;
      ovr_data = vecs[i].instr;
      pulse_pcen(2'b11, vecs[i].start_pc);
      check($sformatf("v%0d_start", i), {16'd0, pc}, {16'd0, vecs[i].start_pc});
      wait_ready($sformatf("v%0d_rdy", i));
      check($sformatf("v%0d_ir", i), {16'd0, opcode, jofs}, {16'd0, vecs[i].instr});
      pulse_pcen(vecs[i].src, vecs[i].ret);
      check($sformatf("v%0d_pc", i), {16'd0, pc}, {16'd0, vecs[i].exp_pc});
      check($sformatf("v%0d_addr", i), {16'd0, bus.imem_addr}, {16'd0, vecs[i].exp_pc});
      check($sformatf("v%0d_req", i), {30'd0, bus.imem_req, ir_valid}, 32'd2);
      wait_ready($sformatf("v%0d_rdy2", i));
    end
    model_pc = pc;
    check("plus1", {16'd0, pc_plus1}, {16'd0, model_pc + 16'd1});

    // ---- stray ack while idle is ignored ----
    ins = instr_at(model_pc);
    @(negedge clk);
    ack_force = 1'b1;
    repeat (2) @(negedge clk);
    ack_force = 1'b0;
    check("stray_ir", {16'd0, opcode, jofs}, {16'd0, ins});
    check("stray_st", {30'd0, bus.imem_req, ir_valid}, 32'd1);

    // ---- randomized PC walk against the model ----
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  s;
      logic [15:0] r;
      s = 2'($urandom_range(0, 3));
      r = 16'($urandom);
      wait_target = $urandom_range(0, 3);
      ins = instr_at(model_pc);
      pulse_pcen(s, r);
      model_pc = model_next(model_pc, ins, s, r);
      check($sformatf("rnd%0d_pc", n), {16'd0, pc}, {16'd0, model_pc});
      wait_ready($sformatf("rnd%0d_rdy", n));
      ins = instr_at(model_pc);
      check($sformatf("rnd%0d_f", n),
            {6'd0, opcode, m, rd, rs1, rs2, i_rd, i_rs1, imm5},
            {6'd0, ins[15:12], ins[11], ins[11:9], ins[8:6], ins[5:3],
             ins[10:8], ins[7:5], ins[4:0]});
    end
    check("rnd_err", {31'd0, pcen_err}, 32'd0);

    // ---- 3 wait cycles, PCen during the wait and on the ack cycle ----
    wait_target = 3;
    pulse_pcen(2'b00, 16'h0000);
    p_hold = model_pc + 16'd1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w%0d_addr", i), {16'd0, bus.imem_addr}, {16'd0, p_hold});
      check($sformatf("w%0d_req", i), {30'd0, bus.imem_req, ir_valid}, 32'd2);
      PCen = (i == 1 || i == 3);
      PCsrc = 2'b11;
      ret_addr = 16'h7777;
      @(negedge clk);
    end
    PCen = 1'b0;
    check("w_irv", {31'd0, ir_valid}, 32'd1);
    check("w_pc", {16'd0, pc}, {16'd0, p_hold});
    check("w_ir", {16'd0, opcode, jofs}, {16'd0, instr_at(p_hold)});
    check("w_err", {31'd0, pcen_err}, 32'd1);
    @(negedge clk);
    check("w_stable", {16'd0, pc}, {16'd0, p_hold});

    // ---- reset mid-fetch ----
    wait_target = 5;
    pulse_pcen(2'b00, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_req", {31'd0, bus.imem_req}, 32'd0);
    check("mid_pc", {16'd0, pc}, 32'h0);
    check("mid_irv", {31'd0, ir_valid}, 32'd0);
    check("mid_err", {31'd0, pcen_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_target = 0;
    @(negedge clk);
    check("re_req", {31'd0, bus.imem_req}, 32'd1);
    check("re_addr", {16'd0, bus.imem_addr}, 32'h0);
    @(negedge clk);
    check("re_irv", {31'd0, ir_valid}, 32'd1);
    check("re_ir", {16'd0, opcode, jofs}, {16'd0, instr_at(16'h0000)});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
